// File: rtl/axi_err_slv_burst.sv
// AXI4 terminating slave for unmapped crossbar ports: every burst completes with RESP, never hangs.
// Optional first-error capture and error counting are enabled by defining ERR_SLV_CAPTURE_EN.
module axi_err_slv_burst #(
   parameter int                 ID_W      = 4,
   parameter int                 ADDR_W    = 32,
   parameter int                 DATA_W    = 32,
   parameter int                 WR_DEPTH  = 4,
   parameter logic [1:0]         RESP      = 2'b11,
   parameter logic [DATA_W-1:0]  RDATA_PAT = DATA_W'(32'hBADCAB1E)
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic [ID_W-1:0]   awid,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic              wlast,
   input  logic              wvalid,
   output logic              wready,
   output logic [ID_W-1:0]   bid,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   input  logic [ID_W-1:0]   arid,
   input  logic [ADDR_W-1:0] araddr,
   input  logic [7:0]        arlen,
   input  logic              arvalid,
   output logic              arready,
   output logic [ID_W-1:0]   rid,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        rresp,
   output logic              rlast,
   output logic              rvalid,
   input  logic              rready,
   input  logic              err_clr,
   output logic [15:0]       err_cnt,
   output logic [ADDR_W-1:0] err_addr
);

   localparam int PTR_W = $clog2(WR_DEPTH);

   typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;

   logic              init_q;
   logic [ID_W-1:0]   id_mem_q [WR_DEPTH];
   logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
   logic              b_pend_q;
   logic              fifo_empty, fifo_full;
   logic              aw_hs, w_last_hs, b_hs, ar_hs, r_hs, r_last_hs;

   rd_state_t         rd_state_q;
   logic              arready_q, rvalid_q, rlast_q;
   logic [ID_W-1:0]   rid_q;
   logic [7:0]        cnt_q;

   // Holds every ready low for the first cycle out of reset.
   always_ff @(posedge aclk) begin
      if (areset) init_q <= 1'b0;
      else        init_q <= 1'b1;
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   assign awready   = init_q && !fifo_full;
   assign wready    = init_q && !fifo_empty && !b_pend_q;
   assign aw_hs     = awvalid && awready;
   assign w_last_hs = wvalid && wready && wlast;
   assign b_hs      = b_pend_q && bready;

   assign bvalid = b_pend_q;
   assign bid    = id_mem_q[rd_ptr_q[PTR_W-1:0]];
   assign bresp  = RESP;

   always_ff @(posedge aclk) begin
      if (aw_hs) id_mem_q[wr_ptr_q[PTR_W-1:0]] <= awid;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         b_pend_q <= 1'b0;
      end else begin
         if (aw_hs) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_last_hs) begin
            b_pend_q <= 1'b1;
         end else if (b_hs) begin
            b_pend_q <= 1'b0;
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   assign arready   = arready_q;
   assign rvalid    = rvalid_q;
   assign rlast     = rlast_q;
   assign rid       = rid_q;
   assign rdata     = RDATA_PAT;
   assign rresp     = RESP;
   assign ar_hs     = arvalid && arready_q;
   assign r_hs      = rvalid_q && rready;
   assign r_last_hs = r_hs && rlast_q;

   // cnt_q counts remaining beats after the current one; rlast is pre-computed one beat ahead.
   always_ff @(posedge aclk) begin
      if (areset) begin
         rd_state_q <= RD_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rlast_q    <= 1'b0;
         rid_q      <= '0;
         cnt_q      <= '0;
      end else begin
         case (rd_state_q)
            RD_IDLE: begin
               arready_q <= 1'b1;
               if (ar_hs) begin
                  rd_state_q <= RD_BURST;
                  arready_q  <= 1'b0;
                  rid_q      <= arid;
                  cnt_q      <= arlen;
                  rvalid_q   <= 1'b1;
                  rlast_q    <= (arlen == 8'd0);
               end
            end
            RD_BURST: begin
               if (r_hs) begin
                  if (rlast_q) begin
                     rd_state_q <= RD_IDLE;
                     rvalid_q   <= 1'b0;
                     rlast_q    <= 1'b0;
                     arready_q  <= 1'b1;
                  end else begin
                     cnt_q   <= cnt_q - 8'd1;
                     rlast_q <= (cnt_q == 8'd1);
                  end
               end
            end
            default: rd_state_q <= RD_IDLE;
         endcase
      end
   end

`ifdef ERR_SLV_CAPTURE_EN
   logic [15:0]       err_cnt_q, err_cnt_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic              armed_q, armed_d;
   logic [1:0]        inc;
   logic [16:0]       sum;

   always_comb begin
      inc        = {1'b0, b_hs} + {1'b0, r_last_hs};
      sum        = {1'b0, err_cnt_q} + {15'd0, inc};
      err_cnt_d  = sum[16] ? 16'hFFFF : sum[15:0];
      err_addr_d = err_addr_q;
      armed_d    = armed_q;
      if (armed_q) begin
         if (ar_hs) begin
            err_addr_d = araddr;
            armed_d    = 1'b0;
         end else if (aw_hs) begin
            err_addr_d = awaddr;
            armed_d    = 1'b0;
         end
      end
      if (err_clr) begin
         err_cnt_d  = '0;
         err_addr_d = '0;
         armed_d    = 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         err_cnt_q  <= '0;
         err_addr_q <= '0;
         armed_q    <= 1'b1;
      end else begin
         err_cnt_q  <= err_cnt_d;
         err_addr_q <= err_addr_d;
         armed_q    <= armed_d;
      end
   end

   assign err_cnt  = err_cnt_q;
   assign err_addr = err_addr_q;
`else
   logic unused_cap;
   assign unused_cap = ^{1'b0, err_clr, awaddr, araddr};
   assign err_cnt    = '0;
   assign err_addr   = '0;
`endif

endmodule

// File: tb/tb_axi_err_slv_burst.sv
// Scoreboard bench for axi_err_slv_burst: expected R/B beats are queued when requests are driven
// and compared as the slave hands them out.
module tb_axi_err_slv_burst;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [3:0]  awid = '0, arid = '0, bid, rid;
   logic [31:0] awaddr = '0, araddr = '0, rdata, err_addr;
   logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
   logic [1:0]  bresp, rresp;
   logic        bvalid, bready = 1'b0;
   logic [7:0]  arlen = '0;
   logic        arvalid = 1'b0, arready, rlast, rvalid, rready = 1'b0;
   logic        err_clr = 1'b0;
   logic [15:0] err_cnt;

   axi_err_slv_burst dut (
      .aclk(aclk), .areset(areset),
      .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .err_clr(err_clr), .err_cnt(err_cnt), .err_addr(err_addr)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [3:0] id;
      logic       last;
   } r_exp_t;

   r_exp_t     rq[$];
   logic [3:0] bq[$];
   int         n_tests = 0;
   int         n_fail  = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Monitor: at the negedge, a valid&&ready pair means a handshake on the coming posedge.
   logic        stall_q = 1'b0;
   logic [3:0]  s_rid;
   logic [31:0] s_rdata;
   logic        s_rlast;
   r_exp_t      mon_e;
   logic [3:0]  mon_b;

   always @(negedge aclk) begin
      if (areset) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            check_val("r_hold_valid", rvalid, 1);
            check_val("r_hold_id", rid, s_rid);
            check_val("r_hold_data", rdata, s_rdata);
            check_val("r_hold_last", rlast, s_rlast);
         end
         stall_q = rvalid && !rready;
         s_rid   = rid;
         s_rdata = rdata;
         s_rlast = rlast;
         if (rvalid && rready) begin
            if (rq.size() == 0) begin
               check_val("r_extra_beat", 1, 0);
            end else begin
               mon_e = rq.pop_front();
               check_val("r_id", rid, mon_e.id);
               check_val("r_data", rdata, 32'hBADCAB1E);
               check_val("r_resp", rresp, 2'b11);
               check_val("r_last", rlast, mon_e.last);
            end
         end
         if (bvalid && bready) begin
            if (bq.size() == 0) begin
               check_val("b_extra", 1, 0);
            end else begin
               mon_b = bq.pop_front();
               check_val("b_id", bid, mon_b);
               check_val("b_resp", bresp, 2'b11);
            end
         end
      end
   end

   task automatic do_ar(input logic [3:0] id, input logic [7:0] len, input logic [31:0] addr);
      logic hs = 1'b0;
      int   n = 0;
      r_exp_t e;
      for (int i = 0; i <= int'(len); i++) begin
         e.id   = id;
         e.last = (i == int'(len));
         rq.push_back(e);
      end
      arid = id; arlen = len; araddr = addr; arvalid = 1'b1;
      while (!hs && n < 400) begin
         @(negedge aclk);
         hs = arready;
         tick();
         n++;
      end
      arvalid = 1'b0;
      check_val("ar_handshake", hs, 1);
   endtask

   task automatic do_aw(input logic [3:0] id, input logic [31:0] addr);
      logic hs = 1'b0;
      int   n = 0;
      bq.push_back(id);
      awid = id; awaddr = addr; awvalid = 1'b1;
      while (!hs && n < 200) begin
         @(negedge aclk);
         hs = awready;
         tick();
         n++;
      end
      awvalid = 1'b0;
      check_val("aw_handshake", hs, 1);
   endtask

   task automatic send_w(input int beats);
      logic hs;
      int   n;
      for (int i = 0; i < beats; i++) begin
         wvalid = 1'b1;
         wlast  = (i == beats - 1);
         hs = 1'b0;
         n  = 0;
         while (!hs && n < 200) begin
            @(negedge aclk);
            hs = wready;
            tick();
            n++;
         end
         check_val("w_handshake", hs, 1);
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((rq.size() + bq.size()) != 0 && n < budget) begin
         tick();
         n++;
      end
      check_val("drain", rq.size() + bq.size(), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset: everything quiet, then one more cycle of ready low after release
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check_val("rst_awready", awready, 0);
      check_val("rst_arready", arready, 0);
      check_val("rst_rvalid", rvalid, 0);
      check_val("rst_bvalid", bvalid, 0);
      check_val("rst_wready", wready, 0);
      tick();
      areset = 1'b0;
      @(negedge aclk);
      check_val("post_rst_arready_low", arready, 0);
      check_val("post_rst_awready_low", awready, 0);
      tick();
      @(negedge aclk);
      check_val("post_rst_arready", arready, 1);
      check_val("post_rst_awready", awready, 1);
      check_val("post_rst_err_cnt", err_cnt, 0);
      check_val("post_rst_err_addr", err_addr, 0);
      tick();

      // Basic 4-beat read burst
      rready = 1'b1;
      bready = 1'b1;
      do_ar(4'd3, 8'd3, 32'h1000_0000);
      drain(100);

      // W ahead of any AW must not be accepted
      wvalid = 1'b1;
      wlast  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         check_val("w_before_aw", wready, 0);
         tick();
      end
      do_aw(4'd5, 32'h0000_0500);
      send_w(1);
      drain(100);

      // Fill the AW FIFO without W, then release with 2-beat writes
      for (int i = 1; i <= 4; i++) do_aw(4'(i), 32'h0000_0100 * i);
      awid = 4'd7;
      awvalid = 1'b1;
      @(negedge aclk);
      check_val("aw_full", awready, 0);
      tick();
      awvalid = 1'b0;
      for (int i = 0; i < 4; i++) send_w(2);
      drain(100);
      @(negedge aclk);
      check_val("aw_after_drain", awready, 1);
      tick();

      // Backpressured read: rready toggles every cycle
      rready = 1'b0;
      do_ar(4'd9, 8'd7, 32'h1000_0100);
      for (int n = 0; n < 200 && rq.size() != 0; n++) begin
         rready = ~rready;
         tick();
      end
      rready = 1'b1;
      drain(50);

      // Length boundaries: single beat and 256 beats
      do_ar(4'd2, 8'd0, 32'h1000_0200);
      drain(50);
      do_ar(4'd14, 8'd255, 32'h1000_0300);
      drain(400);

      // Reset in the middle of a 16-beat burst
      do_ar(4'd10, 8'd15, 32'h1000_0400);
      repeat (4) tick();
      areset = 1'b1;
      tick();
      rq.delete();
      @(negedge aclk);
      check_val("abort_rvalid", rvalid, 0);
      tick();
      areset = 1'b0;
      @(negedge aclk);
      check_val("abort_rvalid_after", rvalid, 0);
      tick();
      @(negedge aclk);
      check_val("abort_arready", arready, 1);
      check_val("abort_rvalid_idle", rvalid, 0);
      tick();
      repeat (5) tick();
      check_val("abort_no_beats", rq.size(), 0);

`ifdef ERR_SLV_CAPTURE_EN
      do_aw(4'd1, 32'h0000_2000);
      send_w(1);
      drain(100);
      do_ar(4'd6, 8'd0, 32'h0000_3000);
      drain(100);
      @(negedge aclk);
      check_val("cap_addr", err_addr, 32'h0000_2000);
      check_val("cap_cnt", err_cnt, 2);
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      @(negedge aclk);
      check_val("clr_cnt", err_cnt, 0);
      check_val("clr_addr", err_addr, 0);
      tick();
      do_ar(4'd8, 8'd1, 32'h0000_4000);
      drain(100);
      @(negedge aclk);
      check_val("recap_addr", err_addr, 32'h0000_4000);
      check_val("recap_cnt", err_cnt, 1);
      tick();
`else
      do_aw(4'd1, 32'h0000_2000);
      send_w(1);
      do_ar(4'd6, 8'd0, 32'h0000_3000);
      drain(100);
      @(negedge aclk);
      check_val("nocap_cnt", err_cnt, 0);
      check_val("nocap_addr", err_addr, 0);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
